// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: issues commands to an external combinational ALU, expands multi-bit
// shifts into shift-by-1 passes, and returns a registered result. Optional busy counter: ALU_SEQ_PERF_CNT_EN.
module alu_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
`ifdef ALU_SEQ_PERF_CNT_EN
  input  logic             perf_clr,
  output logic [31:0]      busy_cycles,
`endif
  input  logic [WIDTH-1:0] alu_y
);

  // state  | meaning
  // S_IDLE | ready for a command, ALU select parked at 000
  // S_EXEC | ALU pass in progress; shifts stay here for cnt passes
  // S_RESP | result presented, waiting for rsp_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_cmd_shift;
  logic             w_op_shift;
  logic             w_exec_done;

  assign w_accept    = cmd_valid & cmd_ready;
  assign w_cmd_shift = (cmd_op == OP_SHL) || (cmd_op == OP_SHR);
  assign w_op_shift  = (r_op == OP_SHL) || (r_op == OP_SHR);
  // A shift leaves EXEC on the pass that consumes the last count.
  assign w_exec_done = !w_op_shift || (r_cnt <= CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_cmd_shift && (cmd_cnt == '0)) w_next = S_RESP;
          else                                w_next = S_EXEC;
        end
      end
      S_EXEC: if (w_exec_done) w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= '0;
      r_acc <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op  <= cmd_op;
      r_acc <= cmd_a;
      r_b   <= cmd_b;
      r_cnt <= cmd_cnt;
    end else if (r_state == S_EXEC) begin
      r_acc <= alu_y;
      if (w_op_shift) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_y     = '0;
    rsp_zero  = 1'b0;
    alu_sel   = 3'b000;
    case (r_state)
      S_IDLE: cmd_ready = !rst;
      S_EXEC: alu_sel = r_op;
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_y     = r_acc;
        rsp_zero  = (r_acc == '0);
      end
      default: ;
    endcase
  end

  assign alu_a = r_acc;
  assign alu_b = r_b;

`ifdef ALU_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_cycles <= '0;
    else if (perf_clr)
      busy_cycles <= '0;
    else if ((r_state != S_IDLE) && (busy_cycles != 32'hFFFF_FFFF))
      busy_cycles <= busy_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: scoreboard bench for alu_seq_ctrl with a behavioural ALU and
// a whole-operation reference model; directed cases followed by random commands.
module tb_alu_seq_ctrl;
  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [CNT_W-1:0] cmd_cnt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_zero;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_y;
`ifdef ALU_SEQ_PERF_CNT_EN
  logic             perf_clr = 1'b0;
  logic [31:0]      busy_cycles;
`endif

  alu_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cnt(cmd_cnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
`ifdef ALU_SEQ_PERF_CNT_EN
    .perf_clr(perf_clr), .busy_cycles(busy_cycles),
`endif
    .alu_y(alu_y)
  );

  always #5 clk = ~clk;

  // Single-pass combinational ALU the controller drives.
  always_comb begin
    case (alu_sel)
      3'b001:  alu_y = alu_a + alu_b;
      3'b010:  alu_y = alu_a & alu_b;
      3'b011:  alu_y = alu_a | alu_b;
      3'b100:  alu_y = alu_a ^ alu_b;
      3'b101:  alu_y = alu_a << 1;
      3'b110:  alu_y = alu_a >> 1;
      3'b111:  alu_y = ~(alu_a ^ alu_b);
      default: alu_y = '0;
    endcase
  end

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             zero;
    int               lat;
    int               acc_cyc;
    int               sels;
    logic [2:0]       op;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   bp_fixed = -1;
  int   last_hs  = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_y(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b, input int n);
    case (op)
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return (n >= WIDTH) ? '0 : (a << n);
      3'b110:  return (n >= WIDTH) ? '0 : (a >> n);
      3'b111:  return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  function automatic bit is_shift(input logic [2:0] op);
    return (op == 3'b101) || (op == 3'b110);
  endfunction

  // Present a command, hold it until accepted, and record what must come back.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input int n, input bit check_b2b);
    exp_t e;
    bit   done = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_cnt   = CNT_W'(n);
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        done      = 1;
        e.y       = ref_y(op, a, b, n);
        e.zero    = (e.y == '0);
        e.lat     = is_shift(op) ? n + 1 : 2;
        e.acc_cyc = cyc;
        e.sels    = is_shift(op) ? n : ((op == 3'b000) ? 0 : 1);
        e.op      = op;
        q.push_back(e);
        if (check_b2b) chk("accept_after_handshake", 64'(cyc), 64'(last_hs + 1));
      end
    end
    if (!done) chk("cmd_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0 && !rsp_valid) ok = 1;
    end
    if (!ok) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on each response handshake.
  bit               seen    = 0;
  int               stall   = 0;
  int               sel_cnt = 0;
  logic [WIDTH-1:0] y_hold;
  logic             z_hold;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen      = 0;
      sel_cnt   = 0;
      rsp_ready = 1'b0;
    end else begin
      if (alu_sel != 3'b000) begin
        sel_cnt++;
        if (q.size() == 0) chk("alu_sel_idle", 64'(alu_sel), 64'd0);
        else               chk("alu_sel_op", 64'(alu_sel), 64'(q[0].op));
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("spurious_rsp", 64'd1, 64'd0);
          rsp_ready = 1'b1;
        end else begin
          if (!seen) begin
            seen   = 1;
            y_hold = rsp_y;
            z_hold = rsp_zero;
            chk("latency", 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
            if (bp_fixed >= 0) begin
              stall    = bp_fixed;
              bp_fixed = -1;
            end else begin
              stall = int'($urandom_range(0, 3));
            end
          end else begin
            chk("rsp_y_stable", 64'(rsp_y), 64'(y_hold));
            chk("rsp_zero_stable", 64'(rsp_zero), 64'(z_hold));
            chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
          end
          if (stall == 0) begin
            e = q.pop_front();
            chk("rsp_y", 64'(rsp_y), 64'(e.y));
            chk("rsp_zero", 64'(rsp_zero), 64'(e.zero));
            chk("exec_passes", 64'(sel_cnt), 64'(e.sels));
            rsp_ready = 1'b1;
            seen      = 0;
            sel_cnt   = 0;
            last_hs   = cyc;
          end else begin
            rsp_ready = 1'b0;
            stall--;
          end
        end
      end else begin
        rsp_ready = 1'b0;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_y"}, 64'(rsp_y), 64'd0);
    chk({tag, "_rsp_zero"}, 64'(rsp_zero), 64'd0);
    chk({tag, "_alu_sel"}, 64'(alu_sel), 64'd0);
    chk({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    chk({tag, "_alu_b"}, 64'(alu_b), 64'd0);
  endtask

  initial begin
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               n;
    rst       = 1'b1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_cnt   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    send(3'b001, 32'd5, 32'd7, 0, 0);
    wait_idle();
    send(3'b100, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 0);
    wait_idle();
    send(3'b101, 32'd1, 32'd0, 4, 0);
    wait_idle();
    send(3'b110, 32'h8000_0000, 32'd0, 31, 0);
    wait_idle();
    send(3'b110, 32'h0000_1234, 32'hFFFF_FFFF, 0, 0);
    wait_idle();
    send(3'b000, 32'hDEAD_BEEF, 32'h1, 0, 0);
    wait_idle();

    bp_fixed = 3;
    send(3'b011, 32'h0F0F_0000, 32'h0000_00F0, 0, 0);
    send(3'b111, 32'h1234_5678, 32'h1234_5678, 0, 1);
    wait_idle();

    send(3'b101, 32'h0000_0003, 32'd0, 20, 0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    send(3'b001, 32'd3, 32'd3, 0, 0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? a : $urandom;
      if ($urandom_range(0, 5) == 0) a = '0;
      n  = int'($urandom_range(0, 31));
      send(op, a, b, n, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
